mem_access_unit: RTL
====================

# mem_access_unit

Load/store responder for the core's memory control outputs (write-enable, partial-access flag, access type). It turns one decoded load or store into a single handshaked transaction on a 32-bit word-addressed data bus. It generates byte enables and lane-replicated write data, then sign- or zero-extends read data back to the register-file write path. It stalls the pipeline while a transaction is outstanding, and it reports misaligned accesses and bus timeouts.

## Interface
- TIMEOUT, 255: maximum cycles to wait for BUS_ACK before aborting (≥1)
- CLK  in  1  clock, all state on rising edge
- RESET_N  in  1  synchronous, active-low reset
- START  in  1  execute-stage load/store request; sampled only in IDLE
- WRITE_MEM  in  1  1 = store, 0 = load
- MEM_PARTIAL  in  1  1 = byte/halfword, 0 = word
- MEM_OPTYPE  in  2  00 ubyte, 01 uhalf, 10 sbyte, 11 shalf; stores use bit 0 only
- ADDR  in  32  byte address
- WDATA  in  32  store data, right-justified
- STALL  out  1  hold pipeline (combinational)
- RDATA  out  32  extended load result (registered)
- RDATA_VALID  out  1  one-cycle pulse, load result ready
- MISALIGN  out  1  one-cycle pulse, access rejected
- BUS_ERR  out  1  one-cycle pulse, timeout abort
- BUS_REQ  out  1  transaction request
- BUS_WE  out  1  write strobe
- BUS_ADDR  out  32  {ADDR[31:2], 2'b00}
- BUS_BE  out  4  byte enables, bit n = bits 8n+7:8n
- BUS_WDATA  out  32  lane-replicated store data
- BUS_ACK  in  1  responder completes the transaction this cycle
- BUS_RDATA  in  32  read word, valid when BUS_ACK=1

## Operation
- FSM states: IDLE and BUS.
- IDLE with START:
  - Size is byte, half or word. Misaligned means half with ADDR[0]=1, or word with ADDR[1:0]≠0.
  - Misaligned: the unit stays in IDLE, pulses MISALIGN next cycle and issues no bus activity.
  - Aligned: the unit latches the request, drives the bus outputs and moves to BUS.
- IDLE without START: nothing happens.
- Byte lanes are little-endian.
  - Byte: BUS_BE = 1<<ADDR[1:0].
  - Half: BUS_BE = ADDR[1] ? 1100 : 0011.
  - Word: BUS_BE = 1111.
- BUS_WDATA for byte = {4{WDATA[7:0]}}, for half = {2{WDATA[15:0]}}, for word = WDATA.
- Load extraction: lane = BUS_RDATA >> (8·ADDR[1:0]).
  - Byte uses lane[7:0]; half uses lane[15:0].
  - MEM_OPTYPE[1] = 1 sign-extends, 0 zero-extends. Word loads are unmodified.
- BUS state:
  - BUS_REQ held high and all bus outputs stable.
  - Wait counter increments every cycle in BUS.
  - BUS_ACK=1: for loads, RDATA captures the extended data and RDATA_VALID pulses; return to IDLE.
  - Counter reaches TIMEOUT with no ACK: drop BUS_REQ, pulse BUS_ERR, return to IDLE. RDATA keeps its previous value.
- STALL = RESET_N & ((IDLE & START & aligned) | BUS).
- START in BUS is ignored. BUS_ACK in IDLE is ignored.
- Counter width is $clog2(TIMEOUT+1); it clears on entry to BUS.

## Timing
- Cycle 0: IDLE with aligned START.
  - STALL=1.
  - Edge 0→1 registers BUS_REQ, BUS_WE, BUS_ADDR, BUS_BE and BUS_WDATA.
- Cycles 1..n: BUS, with STALL=1. n is the first cycle where BUS_ACK=1.
- Cycle n+1: IDLE with BUS_REQ=0 and STALL=0.
  - Load: RDATA valid and RDATA_VALID=1 for exactly this cycle.
  - A new START is accepted in this same cycle (back-to-back).
- Minimum latency is 2 cycles of STALL (ACK in cycle 1).
- Timeout: with no ACK, BUS_REQ stays high for exactly TIMEOUT cycles. BUS_ERR=1 in the next cycle; an ACK arriving in that cycle is ignored.
- Misaligned START: STALL=0 in cycle 0; MISALIGN=1 in cycle 1.
- Reset values, all registered outputs and the FSM: BUS_REQ, BUS_WE, BUS_BE=0; BUS_ADDR, BUS_WDATA, RDATA=0; RDATA_VALID, MISALIGN, BUS_ERR=0; state IDLE; counter 0. STALL=0 while RESET_N=0.
- Reset mid-transaction: BUS_REQ is 0 after the reset edge, no RDATA_VALID or BUS_ERR pulse, and any later ACK is ignored.
- Bus outputs other than BUS_REQ hold their last values in IDLE.

## Test plan
- **Word store, immediate ACK:** WRITE_MEM=1, MEM_PARTIAL=0, ADDR=0x100, WDATA=0xDEADBEEF, ACK in cycle 1 → BUS_REQ=1 in cycle 1 with BUS_BE=1111, BUS_ADDR=0x100, BUS_WDATA=0xDEADBEEF; STALL high in cycles 0–1; no RDATA_VALID.
- **Signed byte load with 3 wait states:** OPTYPE=10, ADDR=0x203, BUS_RDATA=0x80112233, ACK in cycle 4 → BUS_BE=1000; RDATA=0xFFFFFF80 and RDATA_VALID pulse in cycle 5; STALL cycles 0–4. Repeat with OPTYPE=00 → RDATA=0x00000080.
- **Halfword store/load lanes:**
  - SH with ADDR=0x42, WDATA=0x1234ABCD → BUS_BE=1100, BUS_WDATA=0xABCDABCD.
  - Then LH with ADDR=0x42, BUS_RDATA=0xABCD0000 → RDATA=0xFFFFABCD.
  - Back-to-back START accepted in the release cycle.
- **Misaligned:** LH at ADDR=0x41, and LW at ADDR=0x42 → MISALIGN pulse, STALL never high, BUS_REQ stays 0.
- **Timeout:** TIMEOUT=4 and no ACK → BUS_REQ high cycles 1–4, BUS_ERR=1 in cycle 5, STALL=0 in cycle 5, RDATA unchanged. A late ACK in cycle 5 causes no RDATA_VALID.
- **Reset mid-transaction:** RESET_N=0 in cycle 2 of a load → all outputs at reset values after the edge. An ACK in the following cycle after RESET_N is released produces no RDATA_VALID. A new START then completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns one decoded load/store into a single handshaked word-bus transaction,
// generating byte enables and replicated store data, and extending load data for the register file.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        write_mem,
  input  logic        mem_partial,
  input  logic [1:0]  mem_optype,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {ST_IDLE, ST_BUS} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r;
  logic [1:0]    optype_r;
  logic          partial_r;
  logic [1:0]    off_r;
  logic [31:0]   rdata_r, bus_addr_r, bus_wdata_r;
  logic [3:0]    bus_be_r;
  logic          rdata_valid_r, misalign_r, bus_err_r, bus_req_r, bus_we_r;

  logic          misalign_s, accept_s, ack_done_s, timeout_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_rep_s, ext_s;
  logic [15:0]   lane_s;

  // Size decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    misalign_s  = 1'b0;
    be_s        = 4'b0000;
    wdata_rep_s = wdata;
    if (!mem_partial) begin
      misalign_s  = (addr[1:0] != 2'b00);
      be_s        = 4'b1111;
      wdata_rep_s = wdata;
    end else if (mem_optype[0]) begin
      misalign_s  = addr[0];
      be_s        = addr[1] ? 4'b1100 : 4'b0011;
      wdata_rep_s = {2{wdata[15:0]}};
    end else begin
      misalign_s  = 1'b0;
      be_s        = 4'b0001 << addr[1:0];
      wdata_rep_s = {4{wdata[7:0]}};
    end
  end

  assign accept_s = (state_r == ST_IDLE) & start & ~misalign_s;

  // Load extraction from the latched byte offset, then sign or zero extension.
  always_comb begin
    lane_s = 16'(bus_rdata >> {off_r, 3'b000});
    ext_s  = bus_rdata;
    if (!partial_r) begin
      ext_s = bus_rdata;
    end else if (optype_r[0]) begin
      ext_s = {{16{optype_r[1] & lane_s[15]}}, lane_s[15:0]};
    end else begin
      ext_s = {{24{optype_r[1] & lane_s[7]}}, lane_s[7:0]};
    end
  end

  // Next-state logic; ACK wins over a timeout landing in the same cycle.
  always_comb begin
    state_s    = state_r;
    ack_done_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_BUS;
        else          state_s = ST_IDLE;
      end
      ST_BUS: begin
        if (bus_ack) begin
          state_s    = ST_IDLE;
          ack_done_s = 1'b1;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          state_s   = ST_IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_BUS;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_s;
  end

  // Bus-side registers, wait counter and response pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r         <= '0;
      optype_r      <= 2'b00;
      partial_r     <= 1'b0;
      off_r         <= 2'b00;
      rdata_r       <= 32'h0000_0000;
      rdata_valid_r <= 1'b0;
      misalign_r    <= 1'b0;
      bus_err_r     <= 1'b0;
      bus_req_r     <= 1'b0;
      bus_we_r      <= 1'b0;
      bus_addr_r    <= 32'h0000_0000;
      bus_be_r      <= 4'b0000;
      bus_wdata_r   <= 32'h0000_0000;
    end else begin
      rdata_valid_r <= 1'b0;
      misalign_r    <= (state_r == ST_IDLE) & start & misalign_s;
      bus_err_r     <= timeout_s;
      if (accept_s) begin
        bus_req_r   <= 1'b1;
        bus_we_r    <= write_mem;
        bus_addr_r  <= {addr[31:2], 2'b00};
        bus_be_r    <= be_s;
        bus_wdata_r <= wdata_rep_s;
        optype_r    <= mem_optype;
        partial_r   <= mem_partial;
        off_r       <= addr[1:0];
        cnt_r       <= '0;
      end else if (state_r == ST_BUS) begin
        cnt_r <= cnt_r + CW'(1);
        if (ack_done_s | timeout_s) bus_req_r <= 1'b0;
        if (ack_done_s && !bus_we_r) begin
          rdata_r       <= ext_s;
          rdata_valid_r <= 1'b1;
        end
      end
    end
  end

  assign stall       = reset_n & (accept_s | (state_r == ST_BUS));
  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;
  assign misalign    = misalign_r;
  assign bus_err     = bus_err_r;
  assign bus_req     = bus_req_r;
  assign bus_we      = bus_we_r;
  assign bus_addr    = bus_addr_r;
  assign bus_be      = bus_be_r;
  assign bus_wdata   = bus_wdata_r;

endmodule
